// File: rtl/ref_list_builder.sv
// H.264 DPB marking table with RefPicList0/1 initial-order builder and lookup.
// Define REF_LIST_B_EN to build RefPicList1 (BUILD1/SWAP states, L1 storage).
module ref_list_builder #(
   parameter int DPB_DEPTH = 16,
   parameter int SLOT_W    = 4,
   parameter int FN_W      = 4,
   parameter int POC_W     = 16,
   parameter int LIST_LEN  = 16
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    start,
   input  logic                    slice_is_b,
   input  logic [FN_W-1:0]         cur_frame_num,
   input  logic signed [POC_W-1:0] cur_poc,
   input  logic [3:0]              num_l0_m1,
   input  logic [3:0]              num_l1_m1,
   input  logic                    mark_valid,
   input  logic [1:0]              mark_op,
   input  logic [SLOT_W-1:0]       mark_slot,
   input  logic [FN_W-1:0]         mark_frame_num,
   input  logic signed [POC_W-1:0] mark_poc,
   input  logic [3:0]              mark_lt_idx,
   output logic                    mark_ready,
   output logic                    busy,
   output logic                    done,
   output logic [4:0]              l0_len,
   output logic [4:0]              l1_len,
   input  logic [3:0]              rd_idx_l0,
   input  logic [3:0]              rd_idx_l1,
   output logic [SLOT_W-1:0]       rd_slot_l0,
   output logic [SLOT_W-1:0]       rd_slot_l1
);

   localparam int KW   = POC_W + 2;
   localparam int LI_W = $clog2(LIST_LEN);
   localparam logic [1:0] S_NONE  = 2'd0;
   localparam logic [1:0] S_SHORT = 2'd1;
   localparam logic [1:0] S_LONG  = 2'd2;

   typedef enum logic [2:0] {IDLE, BUILD0, BUILD1, SWAP, FIN} state_t;
   state_t state, nstate;

   logic [1:0]              st     [DPB_DEPTH];
   logic [1:0]              st_nx  [DPB_DEPTH];
   logic [FN_W-1:0]         fn     [DPB_DEPTH];
   logic [FN_W-1:0]         fn_nx  [DPB_DEPTH];
   logic signed [POC_W-1:0] poc    [DPB_DEPTH];
   logic signed [POC_W-1:0] poc_nx [DPB_DEPTH];
   logic [3:0]              lt     [DPB_DEPTH];
   logic [3:0]              lt_nx  [DPB_DEPTH];
   logic [SLOT_W-1:0]       l0     [LIST_LEN];

   logic [DPB_DEPTH-1:0] ref_now, ref_nx, taken, taken_nx;
   logic [SLOT_W-1:0]    scan, best_slot, sel_slot;
   logic [KW+1:0]        key, best_key;
   logic signed [FN_W:0] fnw;
   logic signed [KW-1:0] pv, v;
   logic [1:0]           cls, mode;
   logic                 best_v, elig, win, scan_last, cand_left;
   logic                 list_end, go, b_in, b_q, filling, lt_side;
   logic [FN_W-1:0]      cfn_q;
   logic signed [POC_W-1:0] cpoc_q;
   logic [4:0]           pos, lim0, lim_cur;
   logic [LI_W-1:0]      pos_i;

   function automatic logic [4:0] clamp_len(input logic [3:0] m1);
      logic [4:0] n;
      n = {1'b0, m1} + 5'd1;
      return (n > 5'(LIST_LEN)) ? 5'(LIST_LEN) : n;
   endfunction

   // Marking: the next table is what the build will see when start coincides
   always_comb begin
      for (int i = 0; i < DPB_DEPTH; i++) begin
         st_nx[i]  = st[i];
         fn_nx[i]  = fn[i];
         poc_nx[i] = poc[i];
         lt_nx[i]  = lt[i];
      end
      if (mark_valid && !busy) begin
         case (mark_op)
            2'd0, 2'd1: begin
               if (mark_op[0]) begin
                  for (int i = 0; i < DPB_DEPTH; i++)
                     if (st[i] == S_LONG && lt[i] == mark_lt_idx)
                        st_nx[i] = S_NONE;
                  lt_nx[mark_slot] = mark_lt_idx;
               end
               st_nx[mark_slot]  = mark_op[0] ? S_LONG : S_SHORT;
               fn_nx[mark_slot]  = mark_frame_num;
               poc_nx[mark_slot] = mark_poc;
            end
            2'd2: st_nx[mark_slot] = S_NONE;
            default:
               for (int i = 0; i < DPB_DEPTH; i++)
                  st_nx[i] = S_NONE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DPB_DEPTH; i++) begin
            st[i]  <= S_NONE;
            fn[i]  <= '0;
            poc[i] <= '0;
            lt[i]  <= '0;
         end
      end else begin
         for (int i = 0; i < DPB_DEPTH; i++) begin
            st[i]  <= st_nx[i];
            fn[i]  <= fn_nx[i];
            poc[i] <= poc_nx[i];
            lt[i]  <= lt_nx[i];
         end
      end
   end

   always_comb begin
      for (int i = 0; i < DPB_DEPTH; i++) begin
         ref_now[i] = (st[i] != S_NONE);
         ref_nx[i]  = (st_nx[i] != S_NONE);
      end
   end

`ifdef REF_LIST_B_EN
   logic [SLOT_W-1:0] l1 [LIST_LEN];
   logic [4:0]        lim1;
   logic              same;
   assign b_in    = slice_is_b;
   assign lim_cur = (state == BUILD1) ? lim1 : lim0;
`else
   logic unused_b;
   assign unused_b = ^{slice_is_b, num_l1_m1, rd_idx_l1};
   assign b_in     = 1'b0;
   assign lim_cur  = lim0;
`endif

   assign go        = start && (state == IDLE || state == FIN);
   assign filling   = (state == BUILD0) || (state == BUILD1);
   assign scan_last = &scan;
   assign mode      = (state == BUILD1) ? 2'd2 : {1'b0, b_q};
   assign pos_i     = pos[LI_W-1:0];

   // Ordering key: smaller wins; class picks the group, v the order inside it
   always_comb begin
      fnw = (fn[scan] > cfn_q)
          ? $signed({1'b0, fn[scan]} - {1'b1, {FN_W{1'b0}}})
          : $signed({1'b0, fn[scan]});
      pv      = {{2{poc[scan][POC_W-1]}}, poc[scan]};
      lt_side = (poc[scan] < cpoc_q);
      cls     = 2'd0;
      v       = '0;
      if (st[scan] == S_LONG) begin
         cls = 2'd2;
         v   = KW'(lt[scan]);
      end else if (mode == 2'd0) begin
         v = -{{(KW-FN_W-1){fnw[FN_W]}}, fnw};
      end else if (mode == 2'd1) begin
         cls = lt_side ? 2'd0 : 2'd1;
         v   = lt_side ? -pv : pv;
      end else begin
         cls = lt_side ? 2'd1 : 2'd0;
         v   = lt_side ? -pv : pv;
      end
      key = {cls, ~v[KW-1], v[KW-2:0]};
   end

   assign elig      = ref_now[scan] && !taken[scan];
   assign win       = elig && (!best_v || key < best_key);
   assign sel_slot  = win ? scan : best_slot;
   assign taken_nx  = taken | (DPB_DEPTH'(1) << sel_slot);
   assign cand_left = |(ref_now & ~taken_nx);
   assign list_end  = filling && scan_last &&
                      (!((pos + 5'd1) < lim_cur) || !cand_left);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= nstate;
   end

   always_comb begin
      nstate = state;
      case (state)
         IDLE, FIN:
            if (go) nstate = ref_nx[0] || |ref_nx ? BUILD0
                           : (b_in ? SWAP : FIN);
            else    nstate = IDLE;
         BUILD0: if (list_end) nstate = b_q ? BUILD1 : FIN;
         BUILD1: if (list_end) nstate = SWAP;
         SWAP:   nstate = FIN;
         default: nstate = IDLE;
      endcase
   end

   always_comb begin
      busy       = filling || (state == SWAP);
      done       = (state == FIN);
      mark_ready = !busy;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cfn_q     <= '0;
         cpoc_q    <= '0;
         b_q       <= 1'b0;
         lim0      <= '0;
         scan      <= '0;
         pos       <= '0;
         taken     <= '0;
         best_v    <= 1'b0;
         best_slot <= '0;
         best_key  <= '0;
         l0_len    <= '0;
         for (int i = 0; i < LIST_LEN; i++) l0[i] <= '0;
`ifdef REF_LIST_B_EN
         lim1   <= '0;
         l1_len <= '0;
         for (int i = 0; i < LIST_LEN; i++) l1[i] <= '0;
`endif
      end else if (go) begin
         cfn_q  <= cur_frame_num;
         cpoc_q <= cur_poc;
         b_q    <= b_in;
         lim0   <= clamp_len(num_l0_m1);
         scan   <= '0;
         pos    <= '0;
         taken  <= '0;
         best_v <= 1'b0;
         l0_len <= '0;
`ifdef REF_LIST_B_EN
         lim1   <= clamp_len(num_l1_m1);
         l1_len <= '0;
`endif
      end else if (filling) begin
         scan <= scan + 1'b1;
         if (scan_last) begin
            best_v <= 1'b0;
`ifdef REF_LIST_B_EN
            if (state == BUILD1) begin
               l1[pos_i] <= sel_slot;
               l1_len    <= pos + 5'd1;
            end else begin
               l0[pos_i] <= sel_slot;
               l0_len    <= pos + 5'd1;
            end
`else
            l0[pos_i] <= sel_slot;
            l0_len    <= pos + 5'd1;
`endif
            pos   <= list_end ? 5'd0 : pos + 5'd1;
            taken <= list_end ? '0 : taken_nx;
         end else if (win) begin
            best_v    <= 1'b1;
            best_slot <= scan;
            best_key  <= key;
         end
`ifdef REF_LIST_B_EN
      end else if (state == SWAP && same) begin
         l1[0] <= l1[1];
         l1[1] <= l1[0];
`endif
      end
   end

   assign rd_slot_l0 = ({1'b0, rd_idx_l0} < l0_len) ? l0[LI_W'(rd_idx_l0)] : '0;

`ifdef REF_LIST_B_EN
   // Identical lists would make bi-prediction degenerate; swap the first two
   always_comb begin
      same = (l1_len == l0_len) && (l1_len > 5'd1);
      for (int i = 0; i < LIST_LEN; i++)
         if ((5'(i) < l1_len) && (l1[i] != l0[i])) same = 1'b0;
   end
   assign rd_slot_l1 = ({1'b0, rd_idx_l1} < l1_len) ? l1[LI_W'(rd_idx_l1)] : '0;
`else
   assign l1_len     = '0;
   assign rd_slot_l1 = '0;
`endif

endmodule

// File: tb/tb_ref_list_builder.sv
// Bench for ref_list_builder: directed steps plus randomized tables checked
// against a sort-based model of the initial reference list order.
module tb_ref_list_builder;
   logic        clk = 1'b0;
   logic        reset_n, start, slice_is_b, mark_valid;
   logic        mark_ready, busy, done;
   logic [3:0]  cur_frame_num, num_l0_m1, num_l1_m1;
   logic [15:0] cur_poc, mark_poc;
   logic [1:0]  mark_op;
   logic [3:0]  mark_slot, mark_frame_num, mark_lt_idx;
   logic [4:0]  l0_len, l1_len;
   logic [3:0]  rd_idx_l0, rd_idx_l1, rd_slot_l0, rd_slot_l1;

   int checks = 0;
   int failures = 0;
   int m_st[16], m_fn[16], m_poc[16], m_lt[16];
   int e_lst[16];
   int e_len;
   int cm_op, cm_slot, cm_fn, cm_poc, cm_lt;

   always #5 clk = ~clk;

   ref_list_builder dut (
      .clk(clk), .reset_n(reset_n), .start(start), .slice_is_b(slice_is_b),
      .cur_frame_num(cur_frame_num), .cur_poc(cur_poc),
      .num_l0_m1(num_l0_m1), .num_l1_m1(num_l1_m1),
      .mark_valid(mark_valid), .mark_op(mark_op), .mark_slot(mark_slot),
      .mark_frame_num(mark_frame_num), .mark_poc(mark_poc),
      .mark_lt_idx(mark_lt_idx), .mark_ready(mark_ready),
      .busy(busy), .done(done), .l0_len(l0_len), .l1_len(l1_len),
      .rd_idx_l0(rd_idx_l0), .rd_idx_l1(rd_idx_l1),
      .rd_slot_l0(rd_slot_l0), .rd_slot_l1(rd_slot_l1)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic mdl_mark(input int op, input int slot, input int fn,
                           input int poc, input int lt);
      if (op == 3) begin
         for (int i = 0; i < 16; i++) m_st[i] = 0;
      end else if (op == 2) begin
         m_st[slot] = 0;
      end else begin
         if (op == 1)
            for (int i = 0; i < 16; i++)
               if (m_st[i] == 2 && m_lt[i] == lt) m_st[i] = 0;
         m_st[slot]  = (op == 1) ? 2 : 1;
         m_fn[slot]  = fn;
         m_poc[slot] = poc;
         m_lt[slot]  = lt;
      end
   endtask

   task automatic do_mark(input int op, input int slot, input int fn,
                          input int poc, input int lt);
      @(negedge clk);
      mark_valid = 1'b1;
      mark_op = 2'(op);
      mark_slot = 4'(slot);
      mark_frame_num = 4'(fn);
      mark_poc = 16'(poc);
      mark_lt_idx = 4'(lt);
      @(negedge clk);
      mark_valid = 1'b0;
      mdl_mark(op, slot, fn & 15, poc, lt & 15);
   endtask

   // mode 0: P, 1: B list0, 2: B list1; sorts (group, value, slot)
   task automatic exp_list(input int mode, input int cfn, input int cpoc,
                           input int lim);
      longint k[16];
      int s_of[16];
      int n, grp, val, fnw, ts;
      longint tk;
      n = 0;
      for (int s = 0; s < 16; s++) begin
         if (m_st[s] != 0) begin
            if (m_st[s] == 2) begin
               grp = 2; val = m_lt[s];
            end else if (mode == 0) begin
               fnw = (m_fn[s] > cfn) ? m_fn[s] - 16 : m_fn[s];
               grp = 0; val = -fnw;
            end else if (mode == 1) begin
               if (m_poc[s] < cpoc) begin grp = 0; val = -m_poc[s]; end
               else begin grp = 1; val = m_poc[s]; end
            end else begin
               if (m_poc[s] > cpoc) begin grp = 0; val = m_poc[s]; end
               else begin grp = 1; val = -m_poc[s]; end
            end
            k[n] = (longint'(grp) * 2000000 + val + 1000000) * 32 + s;
            s_of[n] = s;
            n++;
         end
      end
      for (int i = 0; i < n; i++)
         for (int j = 0; j < n - 1 - i; j++)
            if (k[j] > k[j+1]) begin
               tk = k[j]; k[j] = k[j+1]; k[j+1] = tk;
               ts = s_of[j]; s_of[j] = s_of[j+1]; s_of[j+1] = ts;
            end
      e_len = (n < lim) ? n : lim;
      for (int i = 0; i < 16; i++) e_lst[i] = (i < e_len) ? s_of[i] : 0;
   endtask

   task automatic run_build(input int b, input int cfn, input int cpoc,
                            input int n0, input int n1, input bit cm,
                            input bit bm, input string tag);
      int e0[16], e1[16];
      int len0, len1, lat, cyc, tmp;
      bit eb, same;
`ifdef REF_LIST_B_EN
      eb = (b != 0);
`else
      eb = 1'b0;
`endif
      @(negedge clk);
      start = 1'b1;
      slice_is_b = (b != 0);
      cur_frame_num = 4'(cfn);
      cur_poc = 16'(cpoc);
      num_l0_m1 = 4'(n0);
      num_l1_m1 = 4'(n1);
      if (cm) begin
         mark_valid = 1'b1;
         mark_op = 2'(cm_op);
         mark_slot = 4'(cm_slot);
         mark_frame_num = 4'(cm_fn);
         mark_poc = 16'(cm_poc);
         mark_lt_idx = 4'(cm_lt);
         mdl_mark(cm_op, cm_slot, cm_fn, cm_poc, cm_lt);
      end
      exp_list(eb ? 1 : 0, cfn, cpoc, n0 + 1);
      e0 = e_lst;
      len0 = e_len;
      if (eb) begin
         exp_list(2, cfn, cpoc, n1 + 1);
         e1 = e_lst;
         len1 = e_len;
      end else begin
         len1 = 0;
         for (int i = 0; i < 16; i++) e1[i] = 0;
      end
      same = eb && len1 > 1 && len1 == len0;
      for (int i = 0; i < len1; i++) if (e1[i] != e0[i]) same = 1'b0;
      if (same) begin
         tmp = e1[0]; e1[0] = e1[1]; e1[1] = tmp;
      end
      lat = 2 + 16 * len0 + (eb ? 16 * len1 + 1 : 0);
      cyc = 1;
      @(negedge clk);
      start = 1'b0;
      mark_valid = 1'b0;
      cyc = 2;
      if (lat > 2) chk({tag, "_busy"}, busy, 1);
      while (done !== 1'b1 && cyc < lat + 40) begin
         mark_valid = 1'b0;
         if (bm && cyc == 5) begin
            chk({tag, "_mark_ready"}, mark_ready, 0);
            mark_valid = 1'b1;
            mark_op = 2'd1;
            mark_slot = 4'd10;
            mark_frame_num = 4'd9;
            mark_poc = 16'(cpoc + 1);
            mark_lt_idx = 4'd0;
         end
         @(negedge clk);
         cyc++;
      end
      mark_valid = 1'b0;
      chk({tag, "_latency"}, cyc, lat);
      chk({tag, "_busy_at_done"}, busy, 0);
      chk({tag, "_l0_len"}, l0_len, len0);
      chk({tag, "_l1_len"}, l1_len, len1);
      for (int i = 0; i < 16; i++) begin
         rd_idx_l0 = 4'(i);
         rd_idx_l1 = 4'(i);
         #1;
         chk($sformatf("%s_l0[%0d]", tag, i), rd_slot_l0, e0[i]);
         chk($sformatf("%s_l1[%0d]", tag, i), rd_slot_l1, e1[i]);
      end
      @(negedge clk);
      chk({tag, "_done_pulse"}, done, 0);
   endtask

   initial begin
      int cpoc, p, nm;
      reset_n = 1'b0; start = 1'b0; slice_is_b = 1'b0; mark_valid = 1'b0;
      cur_frame_num = '0; cur_poc = '0; num_l0_m1 = '0; num_l1_m1 = '0;
      mark_op = '0; mark_slot = '0; mark_frame_num = '0; mark_poc = '0;
      mark_lt_idx = '0; rd_idx_l0 = '0; rd_idx_l1 = '0;
      cm_op = 0; cm_slot = 0; cm_fn = 0; cm_poc = 0; cm_lt = 0;
      for (int i = 0; i < 16; i++) begin
         m_st[i] = 0; m_fn[i] = 0; m_poc[i] = 0; m_lt[i] = 0;
      end
      repeat (2) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_mark_ready", mark_ready, 1);
      chk("rst_l0_len", l0_len, 0);
      chk("rst_l1_len", l1_len, 0);
      chk("rst_rd_l0", rd_slot_l0, 0);
      chk("rst_rd_l1", rd_slot_l1, 0);
      reset_n = 1'b1;
      run_build(0, 0, 0, 3, 3, 0, 0, "empty_after_reset");

      for (int i = 0; i < 4; i++) do_mark(0, i, i + 1, 10 * i, 0);
      run_build(0, 5, 100, 3, 3, 0, 0, "p_basic");
      rd_idx_l0 = 4'd0; #1;
      chk("p_basic_first", rd_slot_l0, 3);

      do_mark(3, 0, 0, 0, 0);
      do_mark(0, 0, 14, 1, 0);
      do_mark(0, 1, 15, 2, 0);
      do_mark(0, 2, 0, 3, 0);
      do_mark(1, 5, 7, 4, 0);
      run_build(0, 1, 50, 3, 3, 0, 0, "p_wrap");
      rd_idx_l0 = 4'd3; #1;
      chk("p_wrap_long", rd_slot_l0, 5);

      do_mark(3, 0, 0, 0, 0);
      do_mark(0, 0, 1, 0, 0);
      do_mark(0, 1, 2, 4, 0);
      do_mark(0, 2, 3, 12, 0);
      do_mark(0, 3, 4, 16, 0);
      run_build(1, 5, 8, 3, 3, 0, 0, "b_four");
`ifdef REF_LIST_B_EN
      rd_idx_l1 = 4'd0; #1;
      chk("b_four_l1_first", rd_slot_l1, 2);
`endif

      do_mark(3, 0, 0, 0, 0);
      do_mark(0, 7, 3, 4, 0);
      do_mark(1, 9, 2, 50, 1);
      run_build(1, 5, 8, 3, 3, 0, 0, "b_swap");
`ifdef REF_LIST_B_EN
      rd_idx_l1 = 4'd0; #1;
      chk("b_swap_l1_first", rd_slot_l1, 9);
`endif

      do_mark(3, 0, 0, 0, 0);
      do_mark(1, 4, 1, 20, 3);
      do_mark(1, 6, 2, 30, 3);
      do_mark(0, 1, 5, 10, 0);
      run_build(0, 6, 0, 7, 7, 0, 0, "dup_lt");
      chk("dup_lt_len", l0_len, 2);

      run_build(0, 6, 0, 7, 7, 0, 1, "busy_mark");
      run_build(0, 6, 0, 7, 7, 0, 0, "after_busy_mark");

      do_mark(3, 0, 0, 0, 0);
      cm_op = 0; cm_slot = 12; cm_fn = 2; cm_poc = -5; cm_lt = 0;
      run_build(1, 3, 0, 2, 2, 1, 0, "same_cycle");

      for (int it = 0; it < 12; it++) begin
         cpoc = int'($urandom_range(200)) - 100;
         do_mark(3, 0, 0, 0, 0);
         nm = int'($urandom_range(10, 1));
         for (int j = 0; j < nm; j++) begin
            do p = int'($urandom_range(200)) - 100; while (p == cpoc);
            do_mark(int'($urandom_range(2)), int'($urandom_range(15)),
                    int'($urandom_range(15)), p, int'($urandom_range(3)));
         end
         run_build(int'($urandom_range(1)), int'($urandom_range(15)), cpoc,
                   int'($urandom_range(15)), int'($urandom_range(15)),
                   0, 0, $sformatf("rand%0d", it));
      end

      do_mark(3, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) do_mark(0, i, i + 1, 10 * i, 0);
      @(negedge clk);
      start = 1'b1; slice_is_b = 1'b0; cur_frame_num = 4'd5;
      num_l0_m1 = 4'd3;
      @(negedge clk);
      start = 1'b0;
      repeat (18) @(negedge clk);
      reset_n = 1'b0;
      #1;
      chk("midrst_busy", busy, 0);
      chk("midrst_done", done, 0);
      chk("midrst_l0_len", l0_len, 0);
      chk("midrst_mark_ready", mark_ready, 1);
      @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 16; i++) m_st[i] = 0;
      run_build(0, 5, 0, 3, 3, 0, 0, "midrst_p");
      run_build(1, 5, 0, 3, 3, 0, 0, "midrst_b");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/ref_list_builder.md
# ref_list_builder

Parametrised reference-picture manager for the H.264 decoder's inter path. It holds the decoded-picture-buffer (DPB) marking table: per-slot reference state, frame_num, POC and long-term index. At each slice start it builds RefPicList0 and, optionally, RefPicList1 in standard initial order. It then serves ref_idx→DPB-slot lookups to the luma and chroma fetch address generators. It sits between the slice-header parser (marking commands, build start) and the motion-compensation read-address mux.

## Interface
Parameters:
- DPB_DEPTH, 16, number of DPB slots (power of two, 2..16)
- SLOT_W, 4, log2(DPB_DEPTH)
- FN_W, 4, frame_num width; MaxFrameNum = 2^FN_W
- POC_W, 16, POC width, signed
- LIST_LEN, 16, maximum list length (num_ref_idx_active_minus1 + 1 ≤ LIST_LEN)

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begin list build for the current slice
- slice_is_b  in  1  B slice (else P)
- cur_frame_num  in  FN_W  frame_num of the current picture
- cur_poc  in  POC_W  POC of the current picture
- num_l0_m1, num_l1_m1  in  4  num_ref_idx_lX_active_minus1
- mark_valid  in  1  marking command strobe
- mark_op  in  2  0 = store short, 1 = store long, 2 = unmark, 3 = unmark all
- mark_slot  in  SLOT_W  target slot
- mark_frame_num  in  FN_W  frame_num stored with op 0/1
- mark_poc  in  POC_W  POC stored with op 0/1
- mark_lt_idx  in  4  long_term_frame_idx for op 1
- mark_ready  out  1  high when marking commands are accepted
- busy  out  1  build in progress
- done  out  1  one-cycle pulse when lists are final
- l0_len, l1_len  out  5  number of valid entries built
- rd_idx_l0, rd_idx_l1  in  4  ref_idx lookup
- rd_slot_l0, rd_slot_l1  out  SLOT_W  DPB slot for that ref_idx, combinational

## Operation
- Table per slot: state (NONE/SHORT/LONG), frame_num, poc, lt_idx. After reset, all slots are NONE.
- Marking is processed only when mark_ready (= !busy). A command issued while busy is dropped. Ops 0/1 overwrite the slot. Op 1 first demotes any other LONG slot holding the same lt_idx to NONE. Op 3 clears all slots in one cycle.
- FrameNumWrap = frame_num − MaxFrameNum if frame_num > cur_frame_num, else frame_num. It is computed in FN_W+1 bits, signed.
- FSM states:
  - IDLE: on start, go to BUILD0.
  - BUILD0: fill L0. Then go to BUILD1 if B, else FIN.
  - BUILD1: fill L1, then go to SWAP.
  - SWAP: apply the L1 swap rule, then go to FIN.
  - FIN: assert done, return to IDLE.
- Fill method is selection: each list position scans all DPB_DEPTH slots, one slot per cycle. The best not-yet-taken candidate is chosen by the ordering key; a per-list taken mask prevents duplicates.
- A position with no candidate ends the list early. A list also ends when it reaches num_lX_m1+1 entries.
- P ordering for L0: SHORT by descending FrameNumWrap, then LONG by ascending lt_idx.
- B ordering for L0: SHORT with poc < cur_poc by descending poc, then SHORT with poc > cur_poc by ascending poc, then LONG ascending lt_idx.
- B ordering for L1: SHORT with poc > cur_poc ascending, then SHORT with poc < cur_poc descending, then LONG ascending.
- SWAP rule: if l1_len > 1 and L1 equals L0 over all entries, exchange L1[0] and L1[1].
- Equal keys resolve to the lowest slot index.
- Lookup with rd_idx ≥ lX_len returns slot 0.

## Timing
- Reset values: busy = 0, done = 0, mark_ready = 1, l0_len = l1_len = 0, all list entries 0, all slots NONE.
- Build latency from the start cycle to done: 1 + (positions_attempted_L0 × DPB_DEPTH) + [B: positions_attempted_L1 × DPB_DEPTH + 1] + 1 cycles.
- busy rises the cycle after start and falls with done.
- start while busy is ignored.
- start and mark_valid in the same cycle: the mark is applied first and the build sees the updated table.
- rd_slot outputs are undefined while busy. They are stable from done until the next start.
- Reset mid-build: returns to IDLE and clears the table and lists.

## Configuration
- REF_LIST_B_EN defined: BUILD1/SWAP exist, and the L1 list registers are implemented.
- REF_LIST_B_EN undefined:
  - slice_is_b is treated as P: L0 uses P ordering, and the FSM goes BUILD0 → FIN.
  - l1_len = 0 and rd_slot_l1 = 0 constant; no L1 storage.

## Test plan
- Reset, then P slice with cur_frame_num=5 and SHORT slots 0..3 holding frame_num 1..4, num_l0_m1=3 → L0 slots {3,2,1,0}, l0_len=4, done after 1+4×16+1 = 66 cycles.
- Wrap: cur_frame_num=1, SHORT frame_nums 14, 15, 0 in slots 0,1,2, plus LONG lt_idx=0 in slot 5 → L0 = {2,1,0,5}.
- B slice with cur_poc=8 and SHORT pocs 0,4,12,16 in slots 0..3 → L0 = {1,0,2,3}, L1 = {2,3,1,0}.
- B slice with a single SHORT (poc 4, slot 7) and a LONG in slot 9 → L0 = L1 = {7,9} before swap; final L1 = {9,7}.
- mark_valid op 1 issued while busy → ignored; the table is unchanged after done. Op 1 with a duplicate lt_idx → the prior LONG slot becomes NONE.
- reset_n low at cycle 20 of a build → busy=0 and all slots NONE. A subsequent start gives l0_len=0 with done after 2 cycles.
